// File: rtl/colormap_lut_if.sv
// Pixel stream and palette-write bundle for colormap_lut.
interface colormap_lut_if #(
    parameter int IW    = 10,
    parameter int LGTBL = 8,
    parameter int LGPAL = 2,
    parameter int CW    = 8
);
    logic             i_wr;
    logic [LGPAL-1:0] i_wr_pal;
    logic [LGTBL-1:0] i_wr_addr;
    logic [3*CW-1:0]  i_wr_data;
    logic             i_valid;
    logic             o_ready;
    logic [IW-1:0]    i_pixel;
    logic [LGPAL-1:0] i_pal_sel;
    logic             i_last;
    logic             o_valid;
    logic             i_ready;
    logic [CW-1:0]    o_r;
    logic [CW-1:0]    o_g;
    logic [CW-1:0]    o_b;
    logic             o_last;

    modport master (
        output i_wr, i_wr_pal, i_wr_addr, i_wr_data,
        output i_valid, i_pixel, i_pal_sel, i_last,
        output i_ready,
        input  o_ready, o_valid, o_r, o_g, o_b, o_last
    );

    modport slave (
        input  i_wr, i_wr_pal, i_wr_addr, i_wr_data,
        input  i_valid, i_pixel, i_pal_sel, i_last,
        input  i_ready,
        output o_ready, o_valid, o_r, o_g, o_b, o_last
    );
endinterface

// File: rtl/colormap_lut.sv
// Pipelined false-colour mapper: palette lookup of two
// neighbouring entries, then linear interpolation on the fraction.
module colormap_lut #(
    parameter int IW    = 10,
    parameter int LGTBL = 8,
    parameter int LGPAL = 2,
    parameter int CW    = 8
) (
    input  logic i_clk,
    input  logic i_reset_n,
    colormap_lut_if.slave bus
);
    localparam int FW   = IW - LGTBL;
    localparam int FWX  = (FW > 0) ? FW : 1;
    localparam int NENT = 1 << LGTBL;
    localparam int NPAL = 1 << LGPAL;
    localparam int AW   = LGPAL + LGTBL;
    localparam int PW   = CW + FWX + 2;
    localparam int DW   = 3 * CW;

    logic en;
    logic acc;
    assign en          = !bus.o_valid || bus.i_ready;
    assign bus.o_ready = en && i_reset_n;
    assign acc         = bus.i_valid && bus.o_ready;

    logic [LGTBL-1:0] k_in;
    logic [LGTBL-1:0] k1_in;
    logic [FWX-1:0]   f_in;
    assign k_in  = bus.i_pixel[IW-1 -: LGTBL];
    assign k1_in = (&k_in) ? k_in : k_in + 1'b1;

    generate
        if (FW > 0) begin : g_frac
            assign f_in = bus.i_pixel[FWX-1:0];
        end else begin : g_nofrac
            assign f_in = '0;
        end
    endgenerate

    // Two palette copies so entries k and k+1 are read together.
    logic [AW-1:0] waddr;
    logic [DW-1:0] mem_a [NPAL*NENT];
    logic [DW-1:0] mem_b [NPAL*NENT];
    assign waddr = {bus.i_wr_pal, bus.i_wr_addr};

    for (genvar j = 0; j < NPAL * NENT; j++) begin : g_ent
        localparam logic [CW-1:0] V =
            CW'((j % NENT) * (2**CW - 1) / (2**LGTBL - 1));
        logic [DW-1:0] ea_q = {V, V, V};
        logic [DW-1:0] eb_q = {V, V, V};
        always_ff @(posedge i_clk) begin
            if (bus.i_wr && waddr == AW'(j)) begin
                ea_q <= bus.i_wr_data;
                eb_q <= bus.i_wr_data;
            end
        end
        assign mem_a[j] = ea_q;
        assign mem_b[j] = eb_q;
    end

    function automatic logic [CW-1:0] lerp(
        input logic [CW-1:0]  a,
        input logic [CW-1:0]  b,
        input logic [FWX-1:0] f
    );
        logic signed [CW:0]   d;
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] s;
        d = $signed({1'b0, b}) - $signed({1'b0, a});
        p = PW'(d) * PW'($signed({1'b0, f}));
        s = p >>> FW;
        return a + s[CW-1:0];
    endfunction

    logic           v0_q, v1_q, v2_q, v3_q;
    logic [AW-1:0]  ka0_q, kb0_q;
    logic [FWX-1:0] f0_q, f1_q, f2_q;
    logic           l0_q, l1_q, l2_q, l3_q;
    logic [DW-1:0]  ra1_q, rb1_q;
    logic [DW-1:0]  a2_q, b2_q;
    logic [DW-1:0]  pix_d, pix_q;

    always_comb begin
        pix_d = '0;
        for (int c = 0; c < 3; c++) begin
            pix_d[c*CW +: CW] = lerp(a2_q[c*CW +: CW],
                                     b2_q[c*CW +: CW], f2_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            v0_q  <= 1'b0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            pix_q <= '0;
            l3_q  <= 1'b0;
        end else if (en) begin
            v0_q  <= acc;
            ka0_q <= {bus.i_pal_sel, k_in};
            kb0_q <= {bus.i_pal_sel, k1_in};
            f0_q  <= f_in;
            l0_q  <= bus.i_last;
            v1_q  <= v0_q;
            ra1_q <= mem_a[ka0_q];
            rb1_q <= mem_b[kb0_q];
            f1_q  <= f0_q;
            l1_q  <= l0_q;
            v2_q  <= v1_q;
            a2_q  <= ra1_q;
            b2_q  <= rb1_q;
            f2_q  <= f1_q;
            l2_q  <= l1_q;
            v3_q  <= v2_q;
            pix_q <= pix_d;
            l3_q  <= l2_q;
        end
    end

    assign bus.o_valid = v3_q;
    assign bus.o_r     = pix_q[2*CW +: CW];
    assign bus.o_g     = pix_q[CW +: CW];
    assign bus.o_b     = pix_q[0 +: CW];
    assign bus.o_last  = l3_q;
endmodule
